irq_pending_arbiter: RTL and testbench
======================================

// Module: irq_pending_arbiter
// PURPOSE
//  Request-capture and grant stage that sits directly upstream of the 8-to-3 priority encode step.
//  Latches 8 asynchronous-event request lines into a pending register, masks them, and picks the
//  highest-index unmasked bit (bit 7 highest priority). Offers the 3-bit code with a valid/ready
//  handshake, and clears the granted bit on acceptance. Flags requests lost to overrun.
// PARAMETERS
//  EDGE     1   1: a pending bit is set on a 0->1 transition of req; 0: set every cycle req bit is 1
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  req        in   8  request lines, sampled on clk
//  mask       in   8  1 = bit excluded from arbitration (still captured into pending)
//  ovr_clr    in   1  clears all overrun flags (synchronous pulse)
//  code       out  3  index of offered request; stable while valid=1
//  valid      out  1  code is a live grant offer
//  ready      in   1  consumer accepts; transfer when valid&ready at a rising edge
//  pending    out  8  current pending register (registered)
//  overrun    out  8  sticky: a new event arrived on a bit that was already pending
// BEHAVIOUR
//  Reset (rst=1 at edge): pending=0, overrun=0, req_q=0, code=0, valid=0, state=IDLE.
//   - req_q=0 after reset, so a req bit held high through reset counts as a rise on the first edge.
//  Capture: req_q <= req every cycle; rise = EDGE ? (req & ~req_q) : req.
//  Clear:   clr = one-hot(code) when valid&ready, else 0.
//  pending <= (pending & ~clr) | rise.
//   - Same-bit set and clear in one cycle: set wins, bit stays 1, no overrun.
//  Overrun: overrun <= ovr_clr ? 0 : overrun | (rise & pending & ~clr).
//   - ovr_clr and a new overrun in the same cycle: clear wins.
//   - With EDGE=0, only a held-high level that hits an already-pending bit can overrun,
//     so overrun is meaningful only when EDGE=1.
//  Eligible set: elig = pending & ~mask.
//   - elig uses the registered pending value, so a bit set this cycle is eligible next cycle.
//  FSM, 2 states:
//   IDLE : elig!=0 -> code <= highest set index of elig, valid <= 1, go OFFER;
//          elig==0 -> stay, valid=0.
//   OFFER: code and valid held stable regardless of mask or new requests (no retraction).
//          valid&ready -> clear pending[code], valid <= 0, go IDLE.
//          else -> stay.
//  Latency: a req rise sampled at edge E0 sets pending at E0, and valid is 1 after E1
//   (2 edges req->valid). Accept at edge Ea drops valid at Ea; the next offer is valid after Ea+1.
//   Maximum throughput: 1 grant per 2 cycles.
//  A bit masked after being offered is still delivered. A masked pending bit stays pending
//   until it is unmasked and granted.
//  Reset mid-OFFER: the offer is abandoned and all pending and overrun state is lost; no grant
//   is issued.
//  ready while valid=0 is ignored. code holds its last value while valid=0.
// TESTING
//  1. rst, then req=8'h28 rising (mask=0, ready=0) -> pending=8'h28, valid=1 code=5 after 2 edges;
//     hold ready=0 10 cycles -> code stays 5.
//  2. From 1, ready=1 -> code 5, then code 3 two cycles later, then valid=0; pending=8'h00 at end.
//  3. mask=8'h80, req=8'h81 -> code=0 granted, pending=8'h80 remains; set mask=0 -> code=7 offered.
//  4. pending[2]=1 not granted (ready=0), req[2] toggles 0->1 -> overrun=8'h04;
//     ovr_clr pulse -> overrun=8'h00.
//  5. Offer code=4 accepted in the same cycle req[4] rises again -> pending[4] stays 1,
//     overrun[4]=0, code=4 re-offered.
//  6. req held 8'hFF through rst release (EDGE=1) -> pending=8'hFF on first edge; assert rst
//     while valid=1 -> valid=0, pending=0 next cycle; EDGE=0 run: req[1] held -> code=1
//     re-granted every 2 cycles.

Source files
------------

// File: rtl/irq_pending_arbiter.sv
// Request-capture and grant stage: latches request events into a pending register and offers the
// highest-index unmasked pending bit as a 3-bit code over a valid/ready handshake.
module irq_pending_arbiter #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       ovr_clr,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pending,
  output logic [7:0] overrun
);

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] overrun_q, overrun_d;
  logic [7:0] req_q;

  logic [7:0] rise;
  logic [7:0] clr;
  logic [7:0] elig;
  logic [2:0] hi_idx;
  logic       accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (elig != 8'h00) state_d = StOffer;
      StOffer: if (ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    valid   = (state_q == StOffer);
    code    = code_q;
    pending = pending_q;
    overrun = overrun_q;
  end

  // Capture, clear and grant selection
  always_comb begin
    rise   = EDGE ? (req & ~req_q) : req;
    accept = (state_q == StOffer) && ready;
    clr    = accept ? (8'd1 << code_q) : 8'h00;
    // Set wins over clear so a same-cycle re-request is never lost
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = ovr_clr ? 8'h00 : (overrun_q | (rise & pending_q & ~clr));
    elig      = pending_q & ~mask;
    hi_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (elig[i]) hi_idx = 3'(i);
    end
    // Code is only reloaded when a new offer starts; it is frozen during the offer
    code_d = ((state_q == StIdle) && (elig != 8'h00)) ? hi_idx : code_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q    <= 3'd0;
      pending_q <= 8'h00;
      overrun_q <= 8'h00;
      req_q     <= 8'h00;
    end else begin
      code_q    <= code_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      req_q     <= req;
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Scoreboard bench: an edge-mode and a level-mode arbiter share stimulus; a reference model
// predicts state and grant codes, and a negedge monitor compares.
module tb_irq_pending_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ovr_clr = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] mask = 8'h00;

  logic [1:0][2:0] code_w;
  logic [1:0]      valid_w;
  logic [1:0][7:0] pending_w;
  logic [1:0][7:0] overrun_w;

  int checks = 0;
  int errors = 0;

  // Index 0: level mode (EDGE=0), index 1: edge mode (EDGE=1)
  irq_pending_arbiter #(.EDGE(1'b0)) u_dut_level (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .mask   (mask),
    .ovr_clr(ovr_clr),
    .code   (code_w[0]),
    .valid  (valid_w[0]),
    .ready  (ready),
    .pending(pending_w[0]),
    .overrun(overrun_w[0])
  );

  irq_pending_arbiter #(.EDGE(1'b1)) u_dut_edge (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .mask   (mask),
    .ovr_clr(ovr_clr),
    .code   (code_w[1]),
    .valid  (valid_w[1]),
    .ready  (ready),
    .pending(pending_w[1]),
    .overrun(overrun_w[1])
  );

  // Reference model state
  logic [7:0] m_pend[2];
  logic [7:0] m_ovr[2];
  logic [7:0] m_prev[2];
  logic [2:0] m_code[2];
  logic       m_valid[2];
  bit         started = 1'b0;
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];

  function automatic logic [2:0] highest(input logic [7:0] v);
    logic [2:0] h = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) h = 3'(i);
    end
    return h;
  endfunction

  task automatic model_step();
    logic [7:0] ev, gone, cand;
    for (int e = 0; e < 2; e++) begin
      if (rst) begin
        m_pend[e]  = 8'h00;
        m_ovr[e]   = 8'h00;
        m_prev[e]  = 8'h00;
        m_code[e]  = 3'd0;
        m_valid[e] = 1'b0;
        if (e == 0) exp_q0.delete();
        else exp_q1.delete();
      end else begin
        ev   = (e == 1) ? (req & ~m_prev[e]) : req;
        gone = (m_valid[e] && ready) ? (8'd1 << m_code[e]) : 8'h00;
        cand = m_pend[e] & ~mask;
        if (m_valid[e]) begin
          if (ready) m_valid[e] = 1'b0;
        end else if (cand != 8'h00) begin
          m_code[e]  = highest(cand);
          m_valid[e] = 1'b1;
          if (e == 0) exp_q0.push_back(m_code[e]);
          else exp_q1.push_back(m_code[e]);
        end
        m_ovr[e]  = ovr_clr ? 8'h00 : (m_ovr[e] | (ev & m_pend[e] & ~gone));
        m_pend[e] = (m_pend[e] & ~gone) | ev;
        m_prev[e] = req;
      end
    end
    if (rst) started = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic chk(input string name, input int e, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, e, $time, act, exp);
    end
  endtask

  // Monitor: per-cycle state compare plus grant scoreboard on each handshake
  initial begin
    logic [2:0] exp_code;
    int qsz;
    forever begin
      @(negedge clk);
      if (started) begin
        for (int e = 0; e < 2; e++) begin
          chk("valid", e, 8'(valid_w[e]), 8'(m_valid[e]));
          chk("code", e, 8'(code_w[e]), 8'(m_code[e]));
          chk("pending", e, pending_w[e], m_pend[e]);
          chk("overrun", e, overrun_w[e], m_ovr[e]);
          if (valid_w[e] === 1'b1 && ready) begin
            qsz = (e == 0) ? exp_q0.size() : exp_q1.size();
            if (qsz == 0) begin
              checks++;
              errors++;
              $display("FAIL grant dut%0d t=%0t actual=%0d expected=none", e, $time, code_w[e]);
            end else begin
              exp_code = (e == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk("grant", e, 8'(code_w[e]), 8'(exp_code));
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic [7:0] rq, input logic [7:0] mk,
                       input logic rd, input logic oc, input int n);
    rst     = r;
    req     = rq;
    mask    = mk;
    ready   = rd;
    ovr_clr = oc;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    drive(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 2);
    // Two requests, offer held without ready, then both drained
    drive(1'b0, 8'h28, 8'h00, 1'b0, 1'b0, 12);
    drive(1'b0, 8'h28, 8'h00, 1'b1, 1'b0, 6);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2);
    // Masked high bit stays pending until unmasked
    drive(1'b0, 8'h81, 8'h80, 1'b1, 1'b0, 4);
    drive(1'b0, 8'h00, 8'h80, 1'b1, 1'b0, 3);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 4);
    // Overrun on a pending bit, then cleared
    drive(1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 3);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2);
    drive(1'b0, 8'h04, 8'h00, 1'b0, 1'b0, 2);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 4);
    // Accept coinciding with a fresh rise on the same bit
    drive(1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 3);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2);
    drive(1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1);
    drive(1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 3);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3);
    // Request held through reset, reset mid-offer, held level request
    drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 2);
    drive(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 3);
    drive(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2);
    drive(1'b0, 8'h02, 8'h00, 1'b1, 1'b0, 8);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 3);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] nreq, nmask;
      nreq  = req ^ 8'($urandom & $urandom);
      nmask = ($urandom_range(0, 15) == 0) ? 8'($urandom & $urandom) : mask;
      drive(($urandom_range(0, 299) == 0), nreq, nmask, 1'($urandom), ($urandom_range(0, 19) == 0),
            1);
    end
    drive(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
